// File: rtl/count_mon_pkg.sv
// Shared types and constants for the down-counter wrap monitor.
// Event word layout: [9:8] type, [7:4] previous sample, [3:0] observed sample.
package count_mon_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int CNT_W        = 4;
    localparam int EVT_W        = 10;
    localparam int EVT_TYPE_LSB = 8;
    localparam int EVT_PREV_LSB = 4;
    localparam int EVT_OBS_LSB  = 0;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_WRAP   = 2'b01;
    localparam logic [1:0] EVT_RESYNC = 2'b10;
    localparam logic [1:0] EVT_FAULT  = 2'b11;

    function automatic logic [EVT_W-1:0] pack_event(
        input logic [1:0]       evt_type,
        input logic [CNT_W-1:0] prev,
        input logic [CNT_W-1:0] obs
    );
        logic [EVT_W-1:0] word;
        word = '0;
        word[EVT_TYPE_LSB +: 2]     = evt_type;
        word[EVT_PREV_LSB +: CNT_W] = prev;
        word[EVT_OBS_LSB  +: CNT_W] = obs;
        return word;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Checks that a 4-bit down counter decrements by one every clock and reports
// wraps, re-resets and sequence faults through an event FIFO.
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        count_in,
    input  logic              clear_fault,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [9:0]        evt_data,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [STAT_W-1:0] drop_cnt,
    output logic              locked,
    output logic              fault
);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    prev_reg, prev_next;
    logic [STAT_W-1:0]   wrap_cnt_reg, wrap_cnt_next;
    logic [STAT_W-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]    exp_val;
    logic [1:0]          evt_type;
    logic                evt_push;
    logic [EVT_W-1:0]    evt_word;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;
    logic                push_ok;

    assign exp_val  = prev_reg - 4'd1;
    assign evt_push = (evt_type != EVT_NONE);
    assign evt_word = pack_event(evt_type, prev_reg, count_in);
    assign pop_fire = !fifo_empty && evt_ready;
    assign push_ok  = !fifo_full || pop_fire;

    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        wrap_cnt_next = wrap_cnt_reg;
        evt_type      = EVT_NONE;
        case (state_reg)
            SYNC: begin
                prev_next  = count_in;
                state_next = TRACK;
            end
            TRACK: begin
                prev_next = count_in;
                if (count_in == exp_val) begin
                    if (prev_reg == 4'd0) begin
                        evt_type      = EVT_WRAP;
                        wrap_cnt_next = wrap_cnt_reg + 1'b1;
                    end
                end else if (count_in == 4'hF) begin
                    // Counter was reset upstream; follow it without faulting.
                    evt_type = EVT_RESYNC;
                end else begin
                    evt_type   = EVT_FAULT;
                    state_next = FAULT;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_next = SYNC;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    // A rejected event is lost, but the statistic saturates rather than wraps.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (evt_push && !push_ok && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= SYNC;
            prev_reg     <= '0;
            wrap_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            prev_reg     <= prev_next;
            wrap_cnt_reg <= wrap_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (evt_push),
        .din   (evt_word),
        .full  (fifo_full),
        .pop   (evt_ready),
        .dout  (evt_data),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign wrap_cnt  = wrap_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign locked    = (state_reg == TRACK);
    assign fault     = (state_reg == FAULT);

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream checker for the 4-bit free-running down counter. Samples the counter value every clock and verifies the strict decrement-by-one sequence. Reports wrap (0→F), counter re-reset (jump to F), and sequence faults as events through a small valid/ready event FIFO, and keeps wrap and drop statistics. Sits between the counter and the system event/status logic.

## Interface
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- STAT_W, 8, width of wrap_cnt and drop_cnt
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- count_in  input  4  counter value, sampled every posedge
- clear_fault  input  1  single-cycle pulse; leaves FAULT state
- evt_ready  input  1  consumer accepts evt_data this cycle
- evt_valid  output  1  FIFO non-empty
- evt_data  output  10  [9:8] type, [7:4] previous sample, [3:0] observed sample
- wrap_cnt  output  STAT_W  number of wrap events, modulo 2^STAT_W
- drop_cnt  output  STAT_W  events lost to full FIFO, saturating at all-ones
- locked  output  1  state == TRACK
- fault  output  1  state == FAULT

## Operation
- States: SYNC, TRACK, FAULT. Reset → SYNC, prev = 0, FIFO empty, all outputs 0.
- SYNC: at next edge capture count_in into prev, go TRACK. No event.
- TRACK, each edge, with exp = (prev − 1) mod 16:
  - count_in == exp, prev ≠ 0: no event.
  - count_in == exp, prev == 0 (0→F): WRAP event (type 01), wrap_cnt += 1 (wraps modulo).
  - count_in ≠ exp, count_in == F: RESYNC event (type 10), stay TRACK (counter was reset).
  - otherwise: FAULT event (type 11), go FAULT.
  - prev ← count_in in all TRACK cases.
- FAULT: count_in ignored, no events, prev frozen. clear_fault → SYNC. clear_fault in SYNC/TRACK ignored.
- FIFO: first-word-fall-through. Pop when evt_valid && evt_ready. Push accepted if not full, or if full and a pop happens the same cycle. Rejected push → drop_cnt += 1 (saturating); the event is lost but state/wrap_cnt still update.
- evt_ready while empty: no effect.

## Timing
- Latency: count_in stable before edge k → event written at edge k → evt_valid = 1 and evt_data valid after edge k (if FIFO was empty).
- wrap_cnt, locked, fault update at the same edge as the triggering sample.
- FIFO throughput one push and one pop per cycle; simultaneous push/pop on non-empty FIFO keeps occupancy constant.
- reset asserted mid-operation: at that edge every state, counter and FIFO entry clears; evt_valid drops the following cycle; pending events are discarded.
- reset overrides clear_fault and any push/pop in the same cycle.

## Structure
- Package count_mon_pkg: state enum (SYNC/TRACK/FAULT), event type constants (EVT_WRAP = 2'b01, EVT_RESYNC = 2'b10, EVT_FAULT = 2'b11), EVT_W = 10, field offsets.
- Sub-module event_fifo: synchronous FWFT FIFO, parameters WIDTH and DEPTH, ports push/din/full, pop/dout/empty. Top contains the FSM, comparator and statistics counters.

## Test plan
- Reset, then drive F,E,…,0,F,E with evt_ready = 1 → locked = 1 after first edge; exactly one WRAP event, evt_data = 10'b01_0000_1111, wrap_cnt = 1.
- In TRACK at prev = 7, drive F → RESYNC event 10'b10_0111_1111, locked stays 1, sequence continues from E without faults.
- In TRACK at prev = 9, drive 3 → FAULT event 10'b11_1001_0011, fault = 1; further arbitrary count_in produces no events; clear_fault pulse → SYNC, then locked = 1 one edge later.
- evt_ready = 0, run 6 full 16-count wraps (DEPTH = 4) → 4 events held, drop_cnt = 2, wrap_cnt = 6; then evt_ready = 1 drains 4 in order, evt_valid drops.
- FIFO full, evt_ready = 1 on the same cycle a WRAP occurs → push accepted, drop_cnt unchanged, occupancy stays 4.
- reset pulse with 3 events queued in TRACK → after that edge evt_valid = 0, wrap_cnt = drop_cnt = 0, locked = 0, state SYNC.
